dmem_backing: RTL and testbench
===============================

# dmem_backing

Backing data memory on the far side of the data cache's miss/write-back port. It answers the cache's single-cycle read strobes (`mrden`) with registered word data one cycle later, and absorbs dirty-line write-backs (`mwren`) into a small write buffer. The buffer drains into a single-port word array whenever no read occupies that array. Reads that hit a pending buffered write are forwarded from the buffer, so the cache always sees the most recent data.

## Interface
- `ADDR_W`, 16, byte address width; word index is `addr[ADDR_W-1:2]`.
- `DATA_W`, 32, word width.
- `WBUF_DEPTH`, 4, write-buffer entries (power of two, ≥2).
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `m_rd_address` input ADDR_W: read byte address, sampled when `mrden`=1.
- `mrden` input 1: read strobe; one request per high cycle.
- `m_wr_address` input ADDR_W: write-back byte address, sampled when `mwren`=1.
- `mwren` input 1: write strobe; one word enqueued per high cycle.
- `data2mem` input DATA_W: write-back word (already masked by the cache).
- `data_in_mem` output DATA_W: read data, registered, held until the next read.
- `rd_valid` output 1: one-cycle pulse, high the cycle `data_in_mem` updates.
- `wbuf_full` output 1: buffer holds WBUF_DEPTH entries.
- `wbuf_empty` output 1: buffer holds zero entries.
- `wbuf_ovf` output 1: sticky; a write arrived while full and was dropped.

## Operation
- Array: 2^(ADDR_W-2) words, single port, one access per cycle. Contents are not reset. Byte offset `addr[1:0]` is ignored on both ports.
- Port priority per cycle: a read (`mrden`=1) owns the array. Otherwise, if the buffer is non-empty, the oldest entry is written to the array and popped.
- Enqueue: `mwren`=1 and not full → push {index, data}. This happens in the same cycle as any drain, so a full buffer plus a drain plus an enqueue stays full and is legal.
- Overflow: `mwren`=1 while full and no drain occurs that cycle (read present) → write dropped, `wbuf_ovf` set. It is cleared only by `rst`.
- Read source priority: the incoming write in the same cycle (`mwren`=1, same index) first, then the youngest matching buffer entry, then the array.
- Duplicate indices in the buffer are allowed. They drain in order, so the array ends with the youngest value.
- Reset mid-operation: all buffered writes are discarded, and an in-flight read produces no `rd_valid`.
- Reset values: `data_in_mem`=0, `rd_valid`=0, `wbuf_full`=0, `wbuf_empty`=1, `wbuf_ovf`=0. Pointers and count are 0.

## Timing
- Read latency is 1 cycle. With `mrden` high in cycle N, `data_in_mem` is valid and `rd_valid`=1 in cycle N+1; the data is held after that. This matches the cache, which captures `data_in_mem` in its MISS state the cycle after its strobe.
- Back-to-back reads are allowed: one per cycle, each with 1-cycle latency. The drain stalls while reads continue.
- Write visibility: a write is forwarded to reads from the cycle it is presented. It reaches the array at the first read-free cycle after the cycle it was enqueued (earliest N+1).
- Flags (`wbuf_full`, `wbuf_empty`) are registered from the count and reflect state after the edge. `wbuf_ovf` rises the cycle after the dropped write.
- Count arithmetic: count is ($clog2(WBUF_DEPTH)+1) bits. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo WBUF_DEPTH.

## Structure
- Package `dmem_pkg` holds `ADDR_W`, `DATA_W`, `WBUF_DEPTH` defaults, the index width `IDX_W = ADDR_W-2`, and the wbuf entry struct {idx, data}.
- Sub-module `dmem_wbuf`: circular FIFO with an associative youngest-match lookup (index in; hit and data out) plus push, pop, full, empty and count.
- Top level: array, port arbitration, read mux/register, overflow flag.

## Test plan
- Read after reset: preload the word at index 5 = 0xDEADBEEF via `mwren` and let it drain. Then `mrden`@0x0014 → next cycle `data_in_mem`=0xDEADBEEF, `rd_valid`=1 for exactly one cycle. The value is still held 3 cycles later.
- Forward, same cycle: `mwren`+`mrden` both @0x0040, data 0x12345678 → read returns 0x12345678. The array is updated one cycle later, confirmed by a later read after `wbuf_empty`=1.
- Youngest match: enqueue 0x1111 then 0x2222 to 0x0080 while continuous reads stall the drain → a read of 0x0080 returns 0x2222. After the drain, the array holds 0x2222.
- Overflow: with `mrden` held high, issue 5 writes → `wbuf_full`=1 after 4 writes, the 5th is dropped, `wbuf_ovf`=1 and stays 1. With `mrden` low, full plus `mwren` does not set `wbuf_ovf`.
- Reset mid-operation: 3 entries buffered and `mrden` high, assert `rst` → `rd_valid`=0, `data_in_mem`=0, `wbuf_empty`=1, `wbuf_ovf`=0. A post-reset read of those addresses returns the pre-write array values.
- Cache pairing: drive the data cache through a dirty eviction followed by a read miss to the evicted line → the cache receives the written-back word on its next miss fill.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and write-buffer entry type for the backing data memory
package dmem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WBUF_DEPTH = 4;
  localparam int IDX_W = ADDR_W - 2;
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/dmem_backing_if.sv
// dmem_backing_if: cache miss/write-back port of the backing data memory
interface dmem_backing_if;
  import dmem_pkg::*;
  logic [ADDR_W-1:0] m_rd_address;
  logic [ADDR_W-1:0] m_wr_address;
  logic mrden;
  logic mwren;
  logic [DATA_W-1:0] data2mem;
  logic [DATA_W-1:0] data_in_mem;
  logic rd_valid;
  logic wbuf_full;
  logic wbuf_empty;
  logic wbuf_ovf;
  modport master (
    output m_rd_address, mrden, m_wr_address, mwren, data2mem,
    input  data_in_mem, rd_valid, wbuf_full, wbuf_empty, wbuf_ovf
  );
  modport slave (
    input  m_rd_address, mrden, m_wr_address, mwren, data2mem,
    output data_in_mem, rd_valid, wbuf_full, wbuf_empty, wbuf_ovf
  );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: circular write FIFO with youngest-match lookup for read forwarding
module dmem_wbuf
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  wbuf_entry_t       din,
  output wbuf_entry_t       head,
  input  logic [IDX_W-1:0]  lidx,
  output logic              hit,
  output logic [DATA_W-1:0] hdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  wbuf_entry_t ent [WBUF_DEPTH];
  logic [PTR_W-1:0] wptr, rptr, k;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) ent[wptr] <= din;
  // scan oldest to youngest so the last live match wins
  always_comb begin
    hit = 1'b0;
    hdata = '0;
    k = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      k = rptr + PTR_W'(i);
      if (CNT_W'(i) < count && ent[k].idx == lidx) begin
        hit = 1'b1;
        hdata = ent[k].data;
      end
    end
  end
  assign head = ent[rptr];
  assign full = count == CNT_W'(WBUF_DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/dmem_backing.sv
// dmem_backing: word memory behind the data cache with a forwarding write buffer
module dmem_backing
  import dmem_pkg::*;
(
  input logic clk,
  input logic rst,
  dmem_backing_if.slave bus
);
  logic [DATA_W-1:0] mem [2**IDX_W];
  wbuf_entry_t head;
  logic [IDX_W-1:0] ridx, widx;
  logic [DATA_W-1:0] hdata, rdata;
  logic [CNT_W-1:0] count;
  logic push, pop, hit, full, empty, unused_ok;
  assign ridx = bus.m_rd_address[ADDR_W-1:2];
  assign widx = bus.m_wr_address[ADDR_W-1:2];
  assign unused_ok = ^{bus.m_rd_address[1:0], bus.m_wr_address[1:0], count};
  // a read owns the single array port; the buffer drains only on read-free cycles
  assign pop = !bus.mrden && !empty;
  assign push = bus.mwren && (!full || pop);
  dmem_wbuf u_wbuf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din('{idx: widx, data: bus.data2mem}),
    .head(head),
    .lidx(ridx),
    .hit(hit),
    .hdata(hdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk)
    if (pop) mem[head.idx] <= head.data;
  assign rdata = (bus.mwren && widx == ridx) ? bus.data2mem : hit ? hdata : mem[ridx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.data_in_mem <= '0;
      bus.rd_valid <= 1'b0;
      bus.wbuf_ovf <= 1'b0;
    end else begin
      bus.rd_valid <= bus.mrden;
      if (bus.mrden) bus.data_in_mem <= rdata;
      if (bus.mwren && full && bus.mrden) bus.wbuf_ovf <= 1'b1;
    end
  assign bus.wbuf_full = full;
  assign bus.wbuf_empty = empty;
endmodule

// File: tb/tb_dmem_backing.sv
// tb_dmem_backing: directed checks of read latency, forwarding, drain, overflow and reset
module tb_dmem_backing;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  dmem_backing_if bus();
  dmem_backing dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rd, input logic [15:0] ra, input logic wr, input logic [15:0] wa,
                     input logic [31:0] wd);
    bus.mrden = rd;
    bus.m_rd_address = ra;
    bus.mwren = wr;
    bus.m_wr_address = wa;
    bus.data2mem = wd;
    @(posedge clk);
    #1;
    bus.mrden = 1'b0;
    bus.mwren = 1'b0;
  endtask
  initial begin
    bus.mrden = 1'b0;
    bus.mwren = 1'b0;
    bus.m_rd_address = '0;
    bus.m_wr_address = '0;
    bus.data2mem = '0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_data", bus.data_in_mem, 32'h0);
    chk("rst_valid", bus.rd_valid, 1'b0);
    chk("rst_full", bus.wbuf_full, 1'b0);
    chk("rst_empty", bus.wbuf_empty, 1'b1);
    chk("rst_ovf", bus.wbuf_ovf, 1'b0);
    rst = 1'b0;
    // preload, drain, read back with one-cycle latency
    cyc(0, 16'h0, 1, 16'h0014, 32'hDEADBEEF);
    chk("pre_empty0", bus.wbuf_empty, 1'b0);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("pre_drained", bus.wbuf_empty, 1'b1);
    cyc(1, 16'h0014, 0, 16'h0, 32'h0);
    chk("rd_data", bus.data_in_mem, 32'hDEADBEEF);
    chk("rd_valid", bus.rd_valid, 1'b1);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("rd_pulse", bus.rd_valid, 1'b0);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("rd_hold", bus.data_in_mem, 32'hDEADBEEF);
    // same-cycle forward, then array holds it
    cyc(1, 16'h0040, 1, 16'h0040, 32'h12345678);
    chk("fwd_same", bus.data_in_mem, 32'h12345678);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("fwd_empty", bus.wbuf_empty, 1'b1);
    cyc(1, 16'h0040, 0, 16'h0, 32'h0);
    chk("fwd_array", bus.data_in_mem, 32'h12345678);
    // youngest buffered match wins while reads stall the drain
    cyc(1, 16'h0000, 1, 16'h0080, 32'h1111);
    cyc(1, 16'h0080, 1, 16'h0080, 32'h2222);
    chk("yng_incoming", bus.data_in_mem, 32'h2222);
    cyc(1, 16'h0080, 0, 16'h0, 32'h0);
    chk("yng_buffer", bus.data_in_mem, 32'h2222);
    chk("yng_pending", bus.wbuf_empty, 1'b0);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("yng_drained", bus.wbuf_empty, 1'b1);
    cyc(1, 16'h0082, 0, 16'h0, 32'h0);
    chk("yng_array", bus.data_in_mem, 32'h2222);
    // fill under reads, full+write without read is legal, full+write with read overflows
    for (int i = 0; i < 4; i++) cyc(1, 16'h0, 1, 16'h0100 + 16'(4 * i), 32'hA0 + i);
    chk("ovf_full", bus.wbuf_full, 1'b1);
    chk("ovf_none", bus.wbuf_ovf, 1'b0);
    cyc(0, 16'h0, 1, 16'h0110, 32'hA4);
    chk("ovf_nord_full", bus.wbuf_full, 1'b1);
    chk("ovf_nord", bus.wbuf_ovf, 1'b0);
    cyc(1, 16'h0, 1, 16'h0114, 32'hA5);
    chk("ovf_set", bus.wbuf_ovf, 1'b1);
    chk("ovf_still_full", bus.wbuf_full, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 16'h0, 32'h0);
    chk("ovf_drained", bus.wbuf_empty, 1'b1);
    chk("ovf_sticky", bus.wbuf_ovf, 1'b1);
    cyc(1, 16'h0110, 0, 16'h0, 32'h0);
    chk("ovf_rd_a4", bus.data_in_mem, 32'hA4);
    cyc(1, 16'h0101, 0, 16'h0, 32'h0);
    chk("ovf_rd_a0", bus.data_in_mem, 32'hA0);
    // reset with buffered writes and a read in flight
    for (int i = 0; i < 3; i++) cyc(1, 16'h0, 1, 16'h0100 + 16'(4 * i), 32'hB0 + i);
    chk("mid_pending", bus.wbuf_empty, 1'b0);
    bus.mrden = 1'b1;
    bus.m_rd_address = 16'h0100;
    #1 rst = 1'b1;
    #1;
    chk("mid_async_data", bus.data_in_mem, 32'h0);
    chk("mid_async_empty", bus.wbuf_empty, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_valid", bus.rd_valid, 1'b0);
    chk("mid_data", bus.data_in_mem, 32'h0);
    chk("mid_empty", bus.wbuf_empty, 1'b1);
    chk("mid_full", bus.wbuf_full, 1'b0);
    chk("mid_ovf", bus.wbuf_ovf, 1'b0);
    bus.mrden = 1'b0;
    rst = 1'b0;
    cyc(1, 16'h0100, 0, 16'h0, 32'h0);
    chk("mid_old0", bus.data_in_mem, 32'hA0);
    cyc(1, 16'h0104, 0, 16'h0, 32'h0);
    chk("mid_old1", bus.data_in_mem, 32'hA1);
    cyc(1, 16'h0108, 0, 16'h0, 32'h0);
    chk("mid_old2", bus.data_in_mem, 32'hA2);
    // dirty eviction followed by a miss fill of the same line
    cyc(0, 16'h0, 1, 16'h0200, 32'hCAFEF00D);
    cyc(1, 16'h0200, 0, 16'h0, 32'h0);
    chk("cache_fill", bus.data_in_mem, 32'hCAFEF00D);
    chk("cache_valid", bus.rd_valid, 1'b1);
    cyc(0, 16'h0, 0, 16'h0, 32'h0);
    cyc(1, 16'h0200, 0, 16'h0, 32'h0);
    chk("cache_array", bus.data_in_mem, 32'hCAFEF00D);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
